// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Handshake and data bundle between a requester and the bit-serial adder.
//   The requester raises start with operands a/b. The adder reports busy while
//   it works, then pulses done for one cycle. sum/carry are valid on done and
//   stay held until the next accepted start.
//
//   Signals (WIDTH = operand width):
//     start  req -> adder   request, only sampled while the adder is idle
//     a, b   req -> adder   operands, captured on the accepted start edge
//     busy   adder -> req   high while the add is in progress
//     done   adder -> req   one-cycle pulse, result valid
//     sum    adder -> req   a+b mod 2^WIDTH
//     carry  adder -> req   carry-out of the MSB
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry
  );
endinterface : serial_adder_if

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder, LSB first. It has one full-adder cell, built
//   from two half adders and an OR, and a carry flip-flop. Each clock adds one
//   bit pair. The result comes back as a parallel sum plus carry-out through
//   a start/busy/done handshake.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (release expected synchronous)
//     bus    serial_adder_if.slave: start/a/b in, busy/done/sum/carry out
//
//   Timing: start is accepted at edge E0. busy is high from E0 through
//   E0+WIDTH. done is high for the cycle after E0+WIDTH. The earliest next
//   accept is at E0+WIDTH+2. All outputs come from registers.
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             c_ff;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;

  // Full-adder cell on the current LSBs: two half adders plus an OR.
  logic ha1_s, ha1_c, ha2_c;
  logic fa_s, fa_c;

  assign ha1_s = op_a[0] ^ op_b[0];
  assign ha1_c = op_a[0] & op_b[0];
  assign fa_s  = ha1_s ^ c_ff;
  assign ha2_c = ha1_s & c_ff;
  assign fa_c  = ha1_c | ha2_c;

  // True on the WIDTH-th ADD edge. That edge produces the MSB of the sum.
  logic last_bit;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: all state updates use non-blocking assignment. Every register then
  // samples the pre-edge values, so the full-adder inputs are consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_ff    <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.b;
            c_ff   <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ADD;
          end
        end

        ADD: begin
          // Result bits enter at the MSB and move right. After WIDTH shifts,
          // bit 0 of the sum has reached position 0.
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          c_ff  <= fa_c;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            carry_q <= fa_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule : serial_adder
